irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller between the timer/counter blocks (TC0, TC1), the external interrupt pin and the CP0 HWInt inputs of the pipelined CPU.
- Latches each source request into a pending register, with a per-source edge or level sense mode.
- Applies a CPU-writable mask, resolves a fixed-priority winner and presents a registered HWInt vector to CP0.
- Occupies word addresses 0x7F20–0x7F2C on the system bridge, alongside TC0 at 0x7F00 and TC1 at 0x7F10.

Parameters:
- N_SRC, 3: number of interrupt sources. Bit 0 = TC0, bit 1 = TC1, bit 2 = external. Legal range 1..6.
- EDGE_MASK, 3'b100: per-source sense mode. 1 = rising-edge sensitive, 0 = level sensitive.
- BASE, 32'h0000_7F20: byte base address of the register window.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- Addr  in  30 ([31:2])  word address from the bridge.
- WE  in  1  write enable, qualified by address hit.
- Din  in  32  write data.
- Dout  out  32  read data, combinational on Addr.
- src  in  N_SRC  raw requests: TC0.IRQ, TC1.IRQ, external pin.
- HWInt  out  6  registered pending&mask, zero-extended to 6 bits, to CP0.
- IRQ  out  1  OR-reduction of HWInt.

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values:
  - pend=0, mask=0, src_prev=0, HWInt=0, IRQ=0.
  - Dout shows the register contents as reset.
- Register map (word offset from BASE):
  - 0x0 PEND: read returns pend. Write is W1C: pend &= ~Din.
  - 0x4 MASK: read/write, low N_SRC bits.
  - 0x8 ID: read-only. Bit 31 = valid (any pend&mask). Bits [2:0] = index of the lowest-numbered set bit of pend&mask, else 0.
  - 0xC SWSET: write-only, pend |= Din. Reads as 0.
- Unused bits read 0.
- Addresses outside the window: Dout=0, no state change.
- Source sampling:
  - Edge source i: set_i = src[i] & ~src_prev[i]. src_prev is updated every cycle.
  - Level source i: set_i = src[i]. The bit re-sets every cycle while src is high, so software must clear the source (e.g. by rewriting TC CTRL) before W1C takes effect.
- Pend update at each posedge: pend_next = (pend & ~w1c) | set | swset.
  - Set wins over a W1C of the same bit in the same cycle.
- HWInt update at each posedge: HWInt <= pend & mask, using pre-edge values.
- Latency, edge source:
  - src first high before posedge k → pend at k → HWInt/IRQ at k+1.
- Latency, MASK write:
  - MASK written at posedge k → HWInt reflects it at k+1.
- An edge source held high across reset release latches once on the first posedge after reset, because src_prev resets to 0.
- Reset mid-operation: all state is cleared immediately (asynchronous). No pending interrupt survives.
- The mask does not gate latching. Masked sources still set pend and fire when later unmasked.
- Writes are single-cycle. No wait states and no handshake beyond WE.

Decomposition:
- Package irq_pkg:
  - Register offsets OFF_PEND/OFF_MASK/OFF_ID/OFF_SWSET.
  - Source index constants SRC_TC0=0, SRC_TC1=1, SRC_EXT=2.
  - HWInt width constant 6.
- Sub-module irq_prio_enc: combinational lowest-index priority encoder (N_SRC → index + valid), used for the ID register.
- Everything else stays in irq_ctrl.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, release. Expect Dout at 0x7F20/24/28 = 0, HWInt=0, IRQ=0.
- Edge on external (src[2]):
  - MASK=3'b111, pulse src[2] 1 cycle. Expect PEND=4 next cycle and HWInt=6'b000100 one cycle later.
  - Hold src[2] high 10 cycles. Expect no re-latch after W1C of 4.
- Level on TC0 (src[0]):
  - Hold src[0]=1, MASK=1. W1C 1 while src high → PEND stays 1.
  - Drop src[0], then W1C 1 → PEND=0, HWInt=0 one cycle later.
- Priority: set src[1] and src[2] together, MASK=6. Expect ID=32'h8000_0001. Then W1C 2 → ID=32'h8000_0002.
- Simultaneous W1C and new edge on the same bit: PEND stays set. Separately, SWSET 3'b011 with MASK=0 → PEND=3, IRQ=0. Then MASK=1 → IRQ=1 after one cycle.
- Async reset mid-operation: with PEND=7 and IRQ=1, assert reset between clock edges. Expect HWInt/IRQ/PEND = 0 immediately, before the next posedge.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg: shared constants for the interrupt controller (register offsets, source indices, HWInt width)
package irq_pkg;
  localparam logic [3:0] OFF_PEND  = 4'h0;
  localparam logic [3:0] OFF_MASK  = 4'h4;
  localparam logic [3:0] OFF_ID    = 4'h8;
  localparam logic [3:0] OFF_SWSET = 4'hC;
  localparam int SRC_TC0 = 0;
  localparam int SRC_TC1 = 1;
  localparam int SRC_EXT = 2;
  localparam int HW_W = 6;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index priority encoder; ports: req (N requests) -> idx (winner), vld (any request)
module irq_prio_enc #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  output logic [2:0]   idx,
  output logic         vld
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) idx = 3'(i);
  end
  assign vld = |req;
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller with pend/mask/ID/SWSET registers feeding CP0 HWInt
// ports: clk, reset (async, active-high); bus Addr/WE/Din/Dout; src raw requests; HWInt registered pend&mask; IRQ = |HWInt
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int              N_SRC     = 3,
  parameter logic [N_SRC-1:0] EDGE_MASK = 3'b100,
  parameter logic [31:0]     BASE      = 32'h0000_7F20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:2]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_SRC-1:0] src,
  output logic [HW_W-1:0]  HWInt,
  output logic             IRQ
);
  logic [N_SRC-1:0] pend, mask, src_prev, set, w1c, swset, pm;
  logic [3:0] off;
  logic [2:0] id_idx;
  logic hit, wr, id_vld, unused_din;
  assign hit = Addr[31:4] == BASE[31:4];
  assign off = {Addr[3:2], 2'b00};
  assign wr = WE & hit;
  assign w1c = (wr && off == OFF_PEND) ? Din[N_SRC-1:0] : '0;
  assign swset = (wr && off == OFF_SWSET) ? Din[N_SRC-1:0] : '0;
  // edge sources need a low->high transition; level sources re-set every cycle while high
  assign set = src & ~(src_prev & EDGE_MASK);
  assign pm = pend & mask;
  assign unused_din = ^Din[31:N_SRC];
  irq_prio_enc #(.N(N_SRC)) u_enc (.req(pm), .idx(id_idx), .vld(id_vld));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
      mask <= '0;
      src_prev <= '0;
      HWInt <= '0;
    end else begin
      pend <= (pend & ~w1c) | set | swset;
      src_prev <= src;
      if (wr && off == OFF_MASK) mask <= Din[N_SRC-1:0];
      HWInt <= HW_W'(pm);
    end
  end
  always_comb
    Dout = !hit              ? '0 :
           off == OFF_PEND   ? 32'(pend) :
           off == OFF_MASK   ? 32'(mask) :
           off == OFF_ID     ? {id_vld, 28'd0, id_idx} : '0;
  assign IRQ = |HWInt;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: table-driven vectors, corner sequences and randomized checks against a behavioural model of irq_ctrl
module tb_irq_ctrl;
  logic clk = 0, reset = 1, WE = 0, IRQ;
  logic [31:2] Addr = '0;
  logic [31:0] Din = '0, Dout;
  logic [2:0] src = '0;
  logic [5:0] HWInt;
  int checks = 0, errors = 0;
  localparam logic [31:0] A_P = 32'h7F20, A_M = 32'h7F24, A_I = 32'h7F28, A_S = 32'h7F2C, A_X = 32'h7F30;
  localparam logic [2:0] EDGE = 3'b100;
  irq_ctrl dut (.clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout),
                .src(src), .HWInt(HWInt), .IRQ(IRQ));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] wa;
    logic        we;
    logic [31:0] din;
    logic [2:0]  s;
    logic [31:0] ra;
    logic [31:0] ed;
    logic [5:0]  eh;
  } vec_t;
  vec_t tv[$];
  logic [2:0] m_pend, m_mask, m_prev, m_hw;
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask
  task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [2:0] s);
    Addr = a[31:2];
    WE = w;
    Din = d;
    src = s;
  endtask
  task automatic rd_check(input string n, input logic [31:0] ra, input logic [31:0] ed, input logic [5:0] eh);
    Addr = ra[31:2];
    WE = 0;
    #1;
    chk({n, "_dout"}, Dout, ed);
    chk({n, "_hwint"}, 32'(HWInt), 32'(eh));
    chk({n, "_irq"}, 32'(IRQ), 32'(eh != 0));
  endtask
  task automatic add(input logic [31:0] wa, input logic we, input logic [31:0] din, input logic [2:0] s,
                     input logic [31:0] ra, input logic [31:0] ed, input logic [5:0] eh);
    tv.push_back('{wa, we, din, s, ra, ed, eh});
  endtask
  task automatic model_step(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [2:0] s);
    logic [2:0] st, p, sw;
    logic in_win;
    in_win = (a >> 4) == 32'h7F2;
    for (int i = 0; i < 3; i++) st[i] = EDGE[i] ? (s[i] && !m_prev[i]) : s[i];
    p = m_pend;
    sw = 0;
    m_hw = m_pend & m_mask;
    if (in_win && w && a[3:0] == 4'h0) p = p & ~d[2:0];
    if (in_win && w && a[3:0] == 4'h4) m_mask = d[2:0];
    if (in_win && w && a[3:0] == 4'hC) sw = d[2:0];
    m_pend = p | st | sw;
    m_prev = s;
  endtask
  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [2:0] pm;
    logic [31:0] id;
    pm = m_pend & m_mask;
    id = 0;
    for (int i = 2; i >= 0; i--) if (pm[i]) id = 32'h8000_0000 + i;
    if ((a >> 4) != 32'h7F2) return 0;
    case (a[3:0])
      4'h0: return {29'd0, m_pend};
      4'h4: return {29'd0, m_mask};
      4'h8: return id;
      default: return 0;
    endcase
  endfunction
  initial begin
    logic [31:0] addrs[6];
    logic [31:0] a, ra, d;
    logic w;
    logic [2:0] s;
    addrs = '{A_P, A_M, A_I, A_S, A_X, 32'h7F1C};
    add(A_M, 1, 7, 0, A_M, 7, 0);
    add(A_P, 0, 0, 4, A_P, 4, 0);
    add(A_P, 0, 0, 0, A_P, 4, 4);
    add(A_P, 0, 0, 4, A_P, 4, 4);
    add(A_P, 1, 4, 4, A_P, 0, 4);
    add(A_P, 0, 0, 4, A_P, 0, 0);
    add(A_P, 0, 0, 4, A_I, 0, 0);
    add(A_M, 1, 1, 5, A_P, 1, 0);
    add(A_P, 1, 1, 5, A_P, 1, 1);
    add(A_P, 0, 0, 4, A_P, 1, 1);
    add(A_P, 1, 1, 0, A_P, 0, 1);
    add(A_P, 0, 0, 0, A_M, 1, 0);
    add(A_M, 1, 6, 6, A_I, 32'h8000_0001, 0);
    add(A_P, 1, 2, 4, A_I, 32'h8000_0002, 6);
    add(A_P, 0, 0, 4, A_P, 4, 4);
    add(A_P, 0, 0, 0, A_P, 4, 4);
    add(A_P, 1, 4, 4, A_P, 4, 4);
    add(A_P, 1, 4, 0, A_P, 0, 4);
    add(A_M, 1, 0, 0, A_P, 0, 0);
    add(A_S, 1, 3, 0, A_P, 3, 0);
    add(A_S, 0, 0, 0, A_S, 0, 0);
    add(A_M, 1, 1, 0, A_I, 32'h8000_0000, 0);
    add(A_P, 0, 0, 0, A_P, 3, 1);
    add(A_X, 1, 32'hFFFF_FFFF, 0, A_X, 0, 1);
    add(A_P, 0, 0, 0, A_M, 1, 1);
    add(A_M, 1, 32'hFFFF_FFFF, 0, A_M, 7, 1);
    add(A_P, 0, 0, 0, A_P, 3, 3);
    cyc;
    cyc;
    reset = 0;
    rd_check("rst_pend", A_P, 0, 0);
    rd_check("rst_mask", A_M, 0, 0);
    rd_check("rst_id", A_I, 0, 0);
    foreach (tv[i]) begin
      drive(tv[i].wa, tv[i].we, tv[i].din, tv[i].s);
      cyc;
      rd_check($sformatf("vec%0d", i), tv[i].ra, tv[i].ed, tv[i].eh);
    end
    drive(A_P, 0, 0, 4);
    reset = 1;
    cyc;
    cyc;
    reset = 0;
    rd_check("held_rst", A_P, 0, 0);
    drive(A_P, 0, 0, 4);
    cyc;
    rd_check("held_latch", A_P, 4, 0);
    drive(A_P, 1, 4, 4);
    cyc;
    rd_check("held_norelatch", A_P, 0, 0);
    drive(A_S, 1, 7, 0);
    cyc;
    drive(A_M, 1, 7, 0);
    cyc;
    drive(A_P, 0, 0, 0);
    cyc;
    rd_check("pre_async", A_P, 7, 7);
    #2 reset = 1;
    rd_check("async_rst", A_P, 0, 0);
    cyc;
    reset = 0;
    m_pend = 0;
    m_mask = 0;
    m_prev = 0;
    m_hw = 0;
    for (int n = 0; n < 300; n++) begin
      a = addrs[$urandom_range(0, 5)];
      w = $urandom_range(0, 2) == 0;
      d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
      s = 3'($urandom_range(0, 7));
      drive(a, w, d, s);
      model_step(a, w, d, s);
      cyc;
      ra = addrs[$urandom_range(0, 5)];
      rd_check($sformatf("rand%0d", n), ra, model_read(ra), {3'b000, m_hw});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
